// File: rtl/dm_sb_master.sv
// dm_sb_master: debug-module system bus master; turns SBA register pulses into single 8/16/32-bit bus transactions.
// Latency: trigger to dbg_req 1 cycle; trigger to read data valid 3 cycles with a zero-wait fabric.
// Backpressure: dbg_req held until dbg_ready; triggers while busy set sbbusyerror. DM_SB_TIMEOUT_EN adds a REQ/RESP timeout.
module dm_sb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [ADDR_WIDTH-1:0] sbaddress0,
  input  logic                  sbaddress0_update,
  input  logic [DATA_WIDTH-1:0] sbdata0,
  input  logic                  sbdata0_update,
  input  logic                  sbdata0_rd,
  input  logic                  sbreadonaddr,
  input  logic [2:0]            sbaccess,
  input  logic [2:0]            sberror_w1,
  input  logic                  sbbusyerror_w1,
  output logic [DATA_WIDTH-1:0] system_bus_read_data,
  output logic                  system_bus_read_data_valid,
  output logic                  sbbusy,
  output logic [2:0]            sberror,
  output logic                  sbbusyerror,
  output logic                  dbg_req,
  output logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_wr,
  output logic [3:0]            dbg_be,
  output logic [DATA_WIDTH-1:0] dbg_wdata,
  input  logic                  dbg_ready,
  input  logic                  dbg_rvalid,
  input  logic [DATA_WIDTH-1:0] dbg_rdata,
  input  logic                  dbg_resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_BUS     = 3'd2;
  localparam logic [2:0] ERR_ALIGN   = 3'd3;
  localparam logic [2:0] ERR_SIZE    = 3'd4;

  // The timeout counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("dm_sb_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t      state;
  state_t      state_next;
  logic        wr_trig;
  logic        rd_trig;
  logic        any_trig;
  logic        blocked;
  logic        size_bad;
  logic        align_bad;
  logic        start;
  logic        busy_set;
  logic        err_set;
  logic [2:0]  err_code;
  logic        rd_ok;
  logic        timeout;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rshift;
  logic [31:0] rdata_c;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;

  // Trigger decode: a write trigger takes priority over a simultaneous read trigger.
  assign wr_trig   = sbdata0_update;
  assign rd_trig   = sbdata0_rd | (sbaddress0_update & sbreadonaddr);
  assign any_trig  = wr_trig | rd_trig;
  assign blocked   = (sberror != 3'd0) | sbbusyerror;
  assign size_bad  = (sbaccess > 3'd2);
  assign align_bad = ((sbaccess == 3'd1) && sbaddress0[0]) ||
                     ((sbaccess == 3'd2) && (sbaddress0[1:0] != 2'b00));
  assign sbbusy    = (state != IDLE);

`ifdef DM_SB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;

  // Wait counter: restarts on every state change, runs while REQ or RESP is waiting.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                  tmo_cnt <= '0;
    else if (state_next != state) tmo_cnt <= '0;
    else if (state != IDLE)       tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign timeout = (state != IDLE) && (tmo_cnt == TMO_LAST);
`else
  assign timeout = 1'b0;
`endif

  // Lane placement for the request: byte enables and replicated write data.
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = 32'd0;
    case (sbaccess)
      3'd0: begin
        be_c    = 4'b0001 << sbaddress0[1:0];
        wdata_c = {4{sbdata0[7:0]}};
      end
      3'd1: begin
        be_c    = sbaddress0[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{sbdata0[15:0]}};
      end
      3'd2: begin
        be_c    = 4'b1111;
        wdata_c = sbdata0[31:0];
      end
      default: ;
    endcase
  end

  // Read return: shift the addressed lane down and zero the bytes outside the access size.
  always_comb begin
    rshift  = dbg_rdata[31:0] >> {lane_q, 3'b000};
    rdata_c = rshift;
    case (size_q)
      2'd0:    rdata_c = {24'd0, rshift[7:0]};
      2'd1:    rdata_c = {16'd0, rshift[15:0]};
      default: rdata_c = rshift;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  // Next state plus the error/launch/return events for this cycle.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    busy_set   = 1'b0;
    err_set    = 1'b0;
    err_code   = 3'd0;
    rd_ok      = 1'b0;
    case (state)
      IDLE: begin
        if (any_trig && !blocked) begin
          if (size_bad) begin
            err_set  = 1'b1;
            err_code = ERR_SIZE;
          end else if (align_bad) begin
            err_set  = 1'b1;
            err_code = ERR_ALIGN;
          end else begin
            start      = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (dbg_ready) begin
          state_next = RESP;
        end else if (timeout) begin
          err_set    = 1'b1;
          err_code   = ERR_TIMEOUT;
          state_next = IDLE;
        end
      end
      RESP: begin
        if (dbg_rvalid) begin
          state_next = IDLE;
          if (dbg_resp_err) begin
            err_set  = 1'b1;
            err_code = ERR_BUS;
          end else if (!dbg_wr) begin
            rd_ok = 1'b1;
          end
        end else if (timeout) begin
          err_set    = 1'b1;
          err_code   = ERR_TIMEOUT;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if ((state != IDLE) && any_trig && !blocked) busy_set = 1'b1;
  end

  // Sticky status: a new error or busy violation wins over a same-cycle clear.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sberror     <= 3'd0;
      sbbusyerror <= 1'b0;
    end else begin
      if (err_set) sberror <= err_code;
      else         sberror <= sberror & ~sberror_w1;
      if (busy_set) sbbusyerror <= 1'b1;
      else          sbbusyerror <= sbbusyerror & ~sbbusyerror_w1;
    end
  end

  // Bus request registers: captured once at launch, request held through REQ.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dbg_req   <= 1'b0;
      dbg_addr  <= '0;
      dbg_be    <= 4'd0;
      dbg_wdata <= '0;
      dbg_wr    <= 1'b0;
      lane_q    <= 2'd0;
      size_q    <= 2'd0;
    end else begin
      dbg_req <= (state_next == REQ);
      if (start) begin
        dbg_addr  <= {sbaddress0[ADDR_WIDTH-1:2], 2'b00};
        dbg_be    <= be_c;
        dbg_wdata <= DATA_WIDTH'(wdata_c);
        dbg_wr    <= wr_trig;
        lane_q    <= sbaddress0[1:0];
        size_q    <= sbaccess[1:0];
      end
    end
  end

  // Read result register and its one-cycle qualifier.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      system_bus_read_data       <= '0;
      system_bus_read_data_valid <= 1'b0;
    end else begin
      system_bus_read_data_valid <= rd_ok;
      if (rd_ok) system_bus_read_data <= DATA_WIDTH'(rdata_c);
    end
  end

endmodule

// File: tb/tb_dm_sb_master.sv
`timescale 1ns/1ps
module tb_dm_sb_master;
  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] sbaddress0;
  logic        sbaddress0_update;
  logic [31:0] sbdata0;
  logic        sbdata0_update;
  logic        sbdata0_rd;
  logic        sbreadonaddr;
  logic [2:0]  sbaccess;
  logic [2:0]  sberror_w1;
  logic        sbbusyerror_w1;
  logic [31:0] system_bus_read_data;
  logic        system_bus_read_data_valid;
  logic        sbbusy;
  logic [2:0]  sberror;
  logic        sbbusyerror;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_wr;
  logic [3:0]  dbg_be;
  logic [31:0] dbg_wdata;
  logic        dbg_ready;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        dbg_resp_err;

  int checks = 0;
  int failures = 0;

  dm_sb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .sbaddress0(sbaddress0), .sbaddress0_update(sbaddress0_update),
    .sbdata0(sbdata0), .sbdata0_update(sbdata0_update), .sbdata0_rd(sbdata0_rd),
    .sbreadonaddr(sbreadonaddr), .sbaccess(sbaccess),
    .sberror_w1(sberror_w1), .sbbusyerror_w1(sbbusyerror_w1),
    .system_bus_read_data(system_bus_read_data),
    .system_bus_read_data_valid(system_bus_read_data_valid),
    .sbbusy(sbbusy), .sberror(sberror), .sbbusyerror(sbbusyerror),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wr(dbg_wr), .dbg_be(dbg_be),
    .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .dbg_resp_err(dbg_resp_err)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: access of 2^s bytes at byte offset a%4 within the word.
  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [2:0] s);
    int n = 1 << s;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [2:0] s);
    if (s == 3'd0) return 32'(d[7:0]) * 32'h0101_0101;
    if (s == 3'd1) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] r, input logic [31:0] a, input logic [2:0] s);
    logic [63:0] mask = (64'd1 << (8 << s)) - 64'd1;
    return 32'((64'(r) >> (8 * (a % 4))) & mask);
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    sbaddress0_update = 1'b0; sbdata0_update = 1'b0; sbdata0_rd = 1'b0;
    sbreadonaddr = 1'b0; sberror_w1 = 3'd0; sbbusyerror_w1 = 1'b0;
    dbg_ready = 1'b0; dbg_rvalid = 1'b0; dbg_resp_err = 1'b0;
  endtask

  task automatic run_txn(input bit is_wr, input bit via_addr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] size, input logic [31:0] rdata,
                         input int rdy_wait, input int rv_wait, input bit err);
    int dropped = 0;
    bit exp_valid = !is_wr && !err;
    sbaddress0 = addr; sbaccess = size; sbdata0 = data;
    if (is_wr) sbdata0_update = 1'b1;
    else if (via_addr) begin sbreadonaddr = 1'b1; sbaddress0_update = 1'b1; end
    else sbdata0_rd = 1'b1;
    tick();
    sbdata0_update = 1'b0; sbaddress0_update = 1'b0; sbdata0_rd = 1'b0; sbreadonaddr = 1'b0;
    checks++; if (dbg_req !== 1'b1 || sbbusy !== 1'b1) begin failures++; $display("FAIL txn_start: req=%b busy=%b want 1/1", dbg_req, sbbusy); end
    checks++; if (dbg_addr !== (addr & ~32'd3)) begin failures++; $display("FAIL txn_addr: got %h want %h", dbg_addr, addr & ~32'd3); end
    checks++; if (dbg_be !== exp_be(addr, size)) begin failures++; $display("FAIL txn_be: got %h want %h", dbg_be, exp_be(addr, size)); end
    checks++; if (dbg_wr !== is_wr) begin failures++; $display("FAIL txn_wr: got %b want %b", dbg_wr, is_wr); end
    if (is_wr) begin
      checks++; if (dbg_wdata !== exp_wdata(data, size)) begin failures++; $display("FAIL txn_wdata: got %h want %h", dbg_wdata, exp_wdata(data, size)); end
    end
    for (int i = 0; i < rdy_wait; i++) begin
      dbg_rvalid = 1'($urandom_range(0, 1));
      dbg_rdata = $urandom;
      tick();
      if (dbg_req !== 1'b1) dropped++;
    end
    dbg_rvalid = 1'b0; dbg_ready = 1'b1;
    tick();
    dbg_ready = 1'b0;
    checks++; if (dropped != 0 || dbg_req !== 1'b0 || sbbusy !== 1'b1) begin failures++; $display("FAIL txn_handshake: dropped=%0d req=%b busy=%b want 0/0/1", dropped, dbg_req, sbbusy); end
    for (int i = 0; i < rv_wait; i++) tick();
    dbg_rvalid = 1'b1; dbg_rdata = rdata; dbg_resp_err = err;
    tick();
    dbg_rvalid = 1'b0; dbg_resp_err = 1'b0;
    checks++; if (sbbusy !== 1'b0) begin failures++; $display("FAIL txn_busy_fall: got %b want 0", sbbusy); end
    checks++; if (system_bus_read_data_valid !== exp_valid) begin failures++; $display("FAIL txn_valid: got %b want %b", system_bus_read_data_valid, exp_valid); end
    if (exp_valid) begin
      checks++; if (system_bus_read_data !== exp_rdata(rdata, addr, size)) begin failures++; $display("FAIL txn_rdata: got %h want %h", system_bus_read_data, exp_rdata(rdata, addr, size)); end
    end
    checks++; if (sberror !== (err ? 3'd2 : 3'd0)) begin failures++; $display("FAIL txn_sberror: got %0d want %0d", sberror, err ? 2 : 0); end
    tick();
    checks++; if (system_bus_read_data_valid !== 1'b0) begin failures++; $display("FAIL txn_valid_once: got %b want 0", system_bus_read_data_valid); end
    if (err) begin
      sberror_w1 = 3'b111; tick(); sberror_w1 = 3'd0;
      checks++; if (sberror !== 3'd0) begin failures++; $display("FAIL txn_err_clear: got %0d want 0", sberror); end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (2) tick();
    sbdata0_update = 1'b1; sbaccess = 3'd2; sbaddress0 = 32'h40;
    tick();
    sbdata0_update = 1'b0;
    checks++; if ({sbbusy, sberror, sbbusyerror, dbg_req, dbg_addr, dbg_be, dbg_wdata, dbg_wr, system_bus_read_data, system_bus_read_data_valid} !== '0) begin
      failures++; $display("FAIL reset_outputs: busy=%b err=%0d berr=%b req=%b addr=%h be=%h wd=%h wr=%b rd=%h v=%b want all 0", sbbusy, sberror, sbbusyerror, dbg_req, dbg_addr, dbg_be, dbg_wdata, dbg_wr, system_bus_read_data, system_bus_read_data_valid); end
    sys_rst = 1'b0;
    tick();
    checks++; if (sbbusy !== 1'b0 || dbg_req !== 1'b0) begin failures++; $display("FAIL reset_release_idle: busy=%b req=%b want 0/0", sbbusy, dbg_req); end
  endtask

  task automatic test_write_32();
    run_txn(1'b1, 1'b0, 32'h2000_0004, 32'hDEAD_BEEF, 3'd2, 32'h0, 0, 0, 1'b0);
  endtask

  task automatic test_read_8();
    run_txn(1'b0, 1'b1, 32'h1000_0003, 32'h0, 3'd0, 32'h1122_3344, 0, 0, 1'b0);
    checks++; if (system_bus_read_data !== 32'h0000_0011) begin failures++; $display("FAIL read8_value: got %h want 00000011", system_bus_read_data); end
  endtask

  task automatic test_errors();
    sbaccess = 3'd1; sbaddress0 = 32'h1; sbdata0_update = 1'b1;
    tick(); sbdata0_update = 1'b0;
    checks++; if (sberror !== 3'd3 || sbbusy !== 1'b0 || dbg_req !== 1'b0) begin failures++; $display("FAIL misaligned: err=%0d busy=%b req=%b want 3/0/0", sberror, sbbusy, dbg_req); end
    sbaccess = 3'd3; sbaddress0 = 32'h0; sbdata0_update = 1'b1;
    tick(); sbdata0_update = 1'b0;
    checks++; if (sberror !== 3'd3 || dbg_req !== 1'b0) begin failures++; $display("FAIL err_sticky: err=%0d req=%b want 3/0", sberror, dbg_req); end
    sberror_w1 = 3'b111; tick(); sberror_w1 = 3'd0;
    checks++; if (sberror !== 3'd0) begin failures++; $display("FAIL err_clear: got %0d want 0", sberror); end
    sbaccess = 3'd7; sbaddress0 = 32'h3; sbdata0_rd = 1'b1;
    tick(); sbdata0_rd = 1'b0;
    checks++; if (sberror !== 3'd4 || dbg_req !== 1'b0) begin failures++; $display("FAIL unsupported_first: err=%0d req=%b want 4/0", sberror, dbg_req); end
    sberror_w1 = 3'b100; tick(); sberror_w1 = 3'd0;
    sbaccess = 3'd2; sbaddress0 = 32'h2; sbdata0_update = 1'b1; sberror_w1 = 3'b111;
    tick(); sbdata0_update = 1'b0; sberror_w1 = 3'd0;
    checks++; if (sberror !== 3'd3) begin failures++; $display("FAIL set_beats_clear: got %0d want 3", sberror); end
    sberror_w1 = 3'b001; tick(); sberror_w1 = 3'd0;
    checks++; if (sberror !== 3'd2) begin failures++; $display("FAIL partial_clear: got %0d want 2", sberror); end
    sberror_w1 = 3'b010; tick(); sberror_w1 = 3'd0;
    checks++; if (sberror !== 3'd0) begin failures++; $display("FAIL final_clear: got %0d want 0", sberror); end
  endtask

  task automatic test_busy_error();
    logic [31:0] r = $urandom;
    sbaccess = 3'd2; sbaddress0 = 32'h40; sbdata0_rd = 1'b1;
    tick(); sbdata0_rd = 1'b0;
    dbg_ready = 1'b1; tick(); dbg_ready = 1'b0;
    sbdata0_rd = 1'b1; tick(); sbdata0_rd = 1'b0;
    checks++; if (sbbusyerror !== 1'b1 || sbbusy !== 1'b1) begin failures++; $display("FAIL busyerr_set: berr=%b busy=%b want 1/1", sbbusyerror, sbbusy); end
    dbg_rvalid = 1'b1; dbg_rdata = r; tick(); dbg_rvalid = 1'b0;
    checks++; if (system_bus_read_data_valid !== 1'b1 || system_bus_read_data !== r) begin failures++; $display("FAIL busyerr_first_read: v=%b data=%h want 1/%h", system_bus_read_data_valid, system_bus_read_data, r); end
    sbdata0_update = 1'b1; sbaddress0 = 32'h0; tick(); sbdata0_update = 1'b0;
    checks++; if (dbg_req !== 1'b0 || sbbusy !== 1'b0 || sbbusyerror !== 1'b1) begin failures++; $display("FAIL busyerr_ignores: req=%b busy=%b berr=%b want 0/0/1", dbg_req, sbbusy, sbbusyerror); end
    sbbusyerror_w1 = 1'b1; tick(); sbbusyerror_w1 = 1'b0;
    checks++; if (sbbusyerror !== 1'b0) begin failures++; $display("FAIL busyerr_clear: got %b want 0", sbbusyerror); end
  endtask

  task automatic test_bus_error();
    run_txn(1'b0, 1'b0, 32'h3000_0000, 32'h0, 3'd2, 32'hCAFE_F00D, 1, 1, 1'b1);
    run_txn(1'b1, 1'b0, 32'h3000_0002, 32'h1234, 3'd1, 32'h0, 0, 2, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r = $urandom;
    sbaccess = 3'd2; sbaddress0 = 32'h100; sbdata0 = 32'h5; sbdata0_update = 1'b1;
    tick(); sbdata0_update = 1'b0;
    dbg_ready = 1'b1; tick(); dbg_ready = 1'b0;
    dbg_rvalid = 1'b1; sbdata0_rd = 1'b1; tick(); dbg_rvalid = 1'b0; sbdata0_rd = 1'b0;
    checks++; if (sbbusyerror !== 1'b1 || sbbusy !== 1'b0 || dbg_req !== 1'b0) begin failures++; $display("FAIL rvalid_same_cycle: berr=%b busy=%b req=%b want 1/0/0", sbbusyerror, sbbusy, dbg_req); end
    sbbusyerror_w1 = 1'b1; tick(); sbbusyerror_w1 = 1'b0;
    sbaccess = 3'd1; sbaddress0 = 32'h202; sbdata0 = 32'hABCD; sbdata0_update = 1'b1; sbdata0_rd = 1'b1;
    tick(); sbdata0_update = 1'b0; sbdata0_rd = 1'b0;
    checks++; if (dbg_wr !== 1'b1 || dbg_req !== 1'b1 || dbg_wdata !== 32'hABCD_ABCD || dbg_be !== 4'b1100) begin failures++; $display("FAIL write_wins: wr=%b req=%b wd=%h be=%h want 1/1/abcdabcd/c", dbg_wr, dbg_req, dbg_wdata, dbg_be); end
    dbg_ready = 1'b1; tick(); dbg_ready = 1'b0;
    dbg_rvalid = 1'b1; tick(); dbg_rvalid = 1'b0;
    sbaccess = 3'd2; sbaddress0 = 32'h300; sbdata0_rd = 1'b1;
    tick(); sbdata0_rd = 1'b0;
    checks++; if (dbg_req !== 1'b1 || dbg_wr !== 1'b0 || sbbusyerror !== 1'b0) begin failures++; $display("FAIL first_idle_accept: req=%b wr=%b berr=%b want 1/0/0", dbg_req, dbg_wr, sbbusyerror); end
    dbg_ready = 1'b1; tick(); dbg_ready = 1'b0;
    dbg_rvalid = 1'b1; dbg_rdata = r; tick(); dbg_rvalid = 1'b0;
    checks++; if (system_bus_read_data_valid !== 1'b1 || system_bus_read_data !== r) begin failures++; $display("FAIL b2b_read: v=%b data=%h want 1/%h", system_bus_read_data_valid, system_bus_read_data, r); end
    tick();
  endtask

  task automatic test_stray();
    dbg_rvalid = 1'b1; dbg_rdata = 32'hFFFF_FFFF; dbg_resp_err = 1'b1;
    tick(); dbg_rvalid = 1'b0; dbg_resp_err = 1'b0;
    checks++; if (system_bus_read_data_valid !== 1'b0 || sbbusy !== 1'b0 || sberror !== 3'd0) begin failures++; $display("FAIL stray_idle: v=%b busy=%b err=%0d want 0/0/0", system_bus_read_data_valid, sbbusy, sberror); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  sz = 3'($urandom_range(0, 2));
      logic [31:0] a  = $urandom & ~((32'd1 << sz) - 32'd1);
      bit          w  = 1'($urandom_range(0, 1));
      bit          va = 1'($urandom_range(0, 1));
      bit          er = ($urandom_range(0, 7) == 0);
      run_txn(w, va, a, $urandom, sz, $urandom, $urandom_range(0, 4), $urandom_range(0, 4), er);
    end
  endtask

`ifdef DM_SB_TIMEOUT_EN
  task automatic test_timeout();
    int hi = 0;
    int busy_cycles = 0;
    sbaccess = 3'd2; sbaddress0 = 32'h80; sbdata0_rd = 1'b1;
    tick(); sbdata0_rd = 1'b0;
    for (int i = 0; i < 40 && dbg_req === 1'b1; i++) begin hi++; tick(); end
    checks++; if (hi != 8 || sberror !== 3'd1 || sbbusy !== 1'b0) begin failures++; $display("FAIL timeout_req: cycles=%0d err=%0d busy=%b want 8/1/0", hi, sberror, sbbusy); end
    dbg_rvalid = 1'b1; dbg_rdata = 32'h55; tick(); dbg_rvalid = 1'b0;
    checks++; if (system_bus_read_data_valid !== 1'b0 || sberror !== 3'd1) begin failures++; $display("FAIL timeout_late_rvalid: v=%b err=%0d want 0/1", system_bus_read_data_valid, sberror); end
    sberror_w1 = 3'b111; tick(); sberror_w1 = 3'd0;
    sbdata0_update = 1'b1; tick(); sbdata0_update = 1'b0;
    dbg_ready = 1'b1; tick(); dbg_ready = 1'b0;
    for (int i = 0; i < 40 && sbbusy === 1'b1; i++) begin busy_cycles++; tick(); end
    checks++; if (busy_cycles != 8 || sberror !== 3'd1) begin failures++; $display("FAIL timeout_resp: cycles=%0d err=%0d want 8/1", busy_cycles, sberror); end
    sberror_w1 = 3'b111; tick(); sberror_w1 = 3'd0;
  endtask
`endif

  task automatic test_reset_mid();
    sbaccess = 3'd2; sbaddress0 = 32'h44; sbdata0_rd = 1'b1;
    tick(); sbdata0_rd = 1'b0;
    dbg_ready = 1'b1; tick(); dbg_ready = 1'b0;
    sys_rst = 1'b1;
    #1;
    checks++; if ({sbbusy, sberror, sbbusyerror, dbg_req, dbg_addr, dbg_be, dbg_wdata, dbg_wr, system_bus_read_data, system_bus_read_data_valid} !== '0) begin
      failures++; $display("FAIL reset_mid: busy=%b req=%b addr=%h be=%h wd=%h rd=%h want all 0", sbbusy, dbg_req, dbg_addr, dbg_be, dbg_wdata, system_bus_read_data); end
    tick(); sys_rst = 1'b0; tick();
    dbg_rvalid = 1'b1; dbg_rdata = 32'h77; tick(); dbg_rvalid = 1'b0;
    checks++; if (system_bus_read_data_valid !== 1'b0 || sbbusy !== 1'b0 || sberror !== 3'd0) begin failures++; $display("FAIL reset_late_resp: v=%b busy=%b err=%0d want 0/0/0", system_bus_read_data_valid, sbbusy, sberror); end
  endtask

  initial begin
    idle_inputs();
    sbaddress0 = '0; sbdata0 = '0; sbaccess = 3'd0; dbg_rdata = '0;
    test_reset();
    test_write_32();
    test_read_8();
    test_errors();
    test_busy_error();
    test_bus_error();
    test_back_to_back();
    test_stray();
    test_random();
`ifdef DM_SB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
